// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store front-end: access sizes, FSM states, word width.
package mem_access_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    DATA = 3'd2,
    WR   = 3'd3,
    ERR  = 3'd4
  } state_e;

  // Encoding 2'b11 behaves as a word access, so bit 1 alone marks a full word.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a loaded byte/half, and merges
// store data into the read word for sub-word read-modify-write.
module lsu_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [1:0]        i_lane,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merged
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic uns);
    logic signed [7:0]        sb;
    logic signed [DATA_W-1:0] sw;
    sb = b;
    sw = DATA_W'(sb);
    return uns ? {{(DATA_W-8){1'b0}}, b} : sw;
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic uns);
    logic signed [15:0]       sh;
    logic signed [DATA_W-1:0] sw;
    sh = h;
    sw = DATA_W'(sh);
    return uns ? {{(DATA_W-16){1'b0}}, h} : sw;
  endfunction

  logic [4:0] w_byte_lsb;
  logic [4:0] w_half_lsb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte_lsb = {i_lane, 3'b000};
  assign w_half_lsb = {i_lane[1], 4'b0000};
  assign w_byte     = i_rdata[w_byte_lsb +: 8];
  assign w_half     = i_rdata[w_half_lsb +: 16];

  always_comb begin
    o_load   = i_rdata;
    o_merged = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_load   = ext_byte(w_byte, i_unsigned);
        o_merged = i_rdata;
        o_merged[w_byte_lsb +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load   = ext_half(w_half, i_unsigned);
        o_merged = i_rdata;
        o_merged[w_half_lsb +: 16] = i_wdata[15:0];
      end
      default: begin
        o_load   = i_rdata;
        o_merged = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-wide memory without byte enables.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete with resp_err.
module mem_access_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import mem_access_pkg::*;

  state_e            r_state;
  state_e            w_next;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [ADDR_W-1:0] w_addr_aligned;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merged;

  // Low address bits that cannot matter for the size are cleared at capture.
  always_comb begin
    w_addr_aligned = req_addr;
    if (is_word(req_size))
      w_addr_aligned[1:0] = 2'b00;
    else if (req_size == SZ_HALF)
      w_addr_aligned[0] = 1'b0;
  end

`ifdef MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_resp_err;
  assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (is_word(req_size) && (req_addr[1:0] != 2'b00));
  assign resp_err   = r_resp_err;
`else
  assign resp_err = 1'b0;
`endif

  lsu_lane_align u_align (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_lane     (r_addr[1:0]),
    .i_rdata    (mem_rdata),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
`ifdef MISALIGN_TRAP_EN
          if (w_misalign)
            w_next = ERR;
          else
`endif
          if (req_we && is_word(req_size))
            w_next = WR;
          else
            w_next = RD;
        end
      end
      RD: begin
        mem_en   = 1'b1;
        mem_addr = r_addr[ADDR_W-1:2];
        w_next   = DATA;
      end
      DATA: w_next = r_we ? WR : IDLE;
      WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_addr[ADDR_W-1:2];
        mem_wdata = r_wdata;
        w_next    = IDLE;
      end
`ifdef MISALIGN_TRAP_EN
      ERR: w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  // r_wdata doubles as the merge buffer so WR always drives from one register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
      r_resp_err   <= 1'b0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= w_addr_aligned;
            r_wdata    <= req_wdata;
          end
        end
        DATA: begin
          if (r_we) begin
            r_wdata <= w_merged;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load;
`ifdef MISALIGN_TRAP_EN
            r_resp_err   <= 1'b0;
`endif
          end
        end
        WR: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
          r_resp_err   <= 1'b0;
`endif
        end
`ifdef MISALIGN_TRAP_EN
        ERR: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end sitting directly upstream of the word-wide main memory: accepts byte-addressed core requests (byte/half/word) over a valid/ready handshake and drives the memory's en/we/address/data_in port.
- Loads: extracts and sign/zero-extends the addressed lane.
- Sub-word stores: read-modify-write, since the memory has no byte enables.
- One instance per core in the lockstep pair.

Parameters:
- ADDR_W, 10, byte-address width; word address = ADDR_W-2 bits (8, 256 words).
- DATA_W, 32, word width; fixed at 32.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- req_valid  in  1  request valid
- req_ready  out  1  unit can accept (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores
- resp_err  out  1  misalignment error (see Optional Feature)
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W-2  word address = captured addr[ADDR_W-1:2]
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; valid the cycle after a read-enable cycle

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset: state=IDLE; captured request regs cleared; resp_valid=0, resp_rdata=0, resp_err=0.
- mem_* are combinational from state: all 0 in IDLE/RESP.
- Handshake: request accepted on a rising edge with req_valid && req_ready. All req_* are captured then. Core may change inputs afterwards.
- States:
  - IDLE: req_ready=1. On accept, go to WR for a word store, else RD.
  - RD: mem_en=1, mem_we=0. Next state is DATA.
  - DATA: mem_rdata valid.
    - Load: register the extracted result into resp_rdata, set resp_valid, go IDLE.
    - Sub-word store: merge and go WR.
  - WR: mem_en=1, mem_we=1. mem_wdata = req_wdata (word store) or merged word (sub-word). Next edge: resp_valid=1, resp_rdata=0, go IDLE.
- Latency, counted as edges after acceptance until resp_valid is high:
  - load: 3
  - word store: 2
  - sub-word store: 4
- resp_valid is high for exactly one cycle, coincident with IDLE. A new request may be accepted in that same cycle (back-to-back, no bubble).
- Lane select:
  - byte lane = addr[1:0], bits [8*lane+7:8*lane].
  - half lane = addr[1], bits [16*addr[1]+15:16*addr[1]].
  - Loads sign-extend from bit 7/15 unless req_unsigned.
- Merge: replace only the selected lane with req_wdata[7:0]/[15:0]; all other bits come from the read word.
- Reset mid-operation: immediate abort to IDLE. A write not yet in WR is never issued. No resp_valid.
- mem_rdata is sampled only in DATA and ignored elsewhere.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, performs no memory access. IDLE goes to ERR for one cycle, then resp_valid=1, resp_err=1, resp_rdata=0 (latency 2).
- Undefined: misaligned low bits are silently forced to alignment (half clears addr[0], word clears addr[1:0]); resp_err is constant 0; ERR state absent.

Decomposition:
- Shared package mem_access_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state encodings IDLE/RD/DATA/WR/ERR
  - DATA_W constant
- One combinational sub-module, lsu_lane_align: lane extract with sign/zero extension, and lane merge for stores. Shared by the load and RMW paths.

Test Plan:
- Word store addr 0x010, data 0xDEADBEEF; then word load 0x010 -> mem write to word 4 two edges after accept; load resp_rdata=0xDEADBEEF three edges after accept.
- Memory word 4 = 0x11223344; store byte 0xAA at 0x012 -> word 4 = 0x11AA3344; byte load 0x012 signed returns 0xFFFFFFAA, unsigned returns 0x000000AA.
- Word 4 = 0x8001_7FFF; half load 0x010 signed returns 0x00007FFF; half load 0x012 signed returns 0xFFFF8001; half store 0x1234 at 0x012 -> word 4 = 0x12347FFF.
- Back-to-back: hold req_valid for two loads -> second accepted in the resp_valid cycle of the first; both results correct; req_ready low in RD/DATA.
- Assert reset_n low during DATA of a sub-word store -> no mem_we pulse, memory unchanged, all outputs 0, req_ready=1 after release.
- Word load at 0x013:
  - with MISALIGN_TRAP_EN: mem_en never high; resp_err=1, resp_rdata=0 two edges later.
  - without: reads word 4 normally, resp_err=0.
